buffer_slot_allocator: RTL

- Controller for a bank of NUM_SLOTS hybrid buffer slots in the aggregation/transformation path.
- Allocates free slots to incoming nodeslots using round-robin order.
- Tracks each slot's lifecycle, queues filled slots in completion order and hands them to the drain-side consumer.
- Returns a slot to the free pool once that slot's slot_free flag reports it empty.

---
 rtl/buffer_slot_allocator_pkg.sv | 19 +
 rtl/buffer_slot_allocator_queue.sv | 61 ++++++
 rtl/buffer_slot_allocator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/buffer_slot_allocator_pkg.sv
// Shared types and sizing helpers for the buffer slot allocator.
package buffer_slot_allocator_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_WRITING  = 2'd1,
        SLOT_QUEUED   = 2'd2,
        SLOT_DRAINING = 2'd3
    } slot_state_e;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/buffer_slot_allocator_queue.sv
// slot_ready_queue: FIFO of filled slot indices in completion order, depth = slot count.
module slot_ready_queue
    import buffer_slot_allocator_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
        return (p == W'(DEPTH - 1)) ? '0 : p + W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop_i && (count_q != '0);
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/buffer_slot_allocator.sv
// Round-robin allocator and lifecycle tracker for a bank of hybrid buffer slots.
// Optional perf counters are enabled by defining BUFFER_SLOT_ALLOCATOR_PERF_EN.
module buffer_slot_allocator
    import buffer_slot_allocator_pkg::*;
#(
    parameter  int NUM_SLOTS  = 8,
    parameter  int NODESLOT_W = 6,
    localparam int SLOT_W     = slot_w(NUM_SLOTS),
    localparam int CNT_W      = cnt_w(NUM_SLOTS)
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  alloc_req_valid,
    input  logic [NODESLOT_W-1:0] alloc_req_nodeslot,
    output logic                  alloc_req_ready,
    output logic                  alloc_resp_valid,
    output logic [SLOT_W-1:0]     alloc_resp_slot,
    input  logic                  write_done_valid,
    input  logic [SLOT_W-1:0]     write_done_slot,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    output logic [SLOT_W-1:0]     drain_slot,
    output logic [NODESLOT_W-1:0] drain_nodeslot,
    input  logic [NUM_SLOTS-1:0]  slot_free_i,
    output logic [CNT_W-1:0]      free_count,
    output logic                  protocol_err
`ifdef BUFFER_SLOT_ALLOCATOR_PERF_EN
    ,
    output logic [31:0]           perf_alloc_count,
    output logic [31:0]           perf_stall_cycles
`endif
);

    slot_state_e           state_q [NUM_SLOTS];
    slot_state_e           state_d [NUM_SLOTS];
    logic [NODESLOT_W-1:0] tag_q [NUM_SLOTS];
    logic [NODESLOT_W-1:0] tag_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  first_q, first_d;
    logic [SLOT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [SLOT_W-1:0]     resp_slot_q, resp_slot_d;
    logic [CNT_W-1:0]      free_count_q, free_count_d;
    logic                  err_q, err_d;

    logic [NUM_SLOTS-1:0]  free_v;
    logic [SLOT_W-1:0]     sel;
    logic                  alloc_fire, wd_ok, pop;
    logic [SLOT_W-1:0]     q_head;
    logic [CNT_W-1:0]      q_count;

    // First FREE slot at or after start, wrapping around the bank.
    function automatic logic [SLOT_W-1:0] rr_pick(input logic [NUM_SLOTS-1:0] fv,
                                                  input logic [SLOT_W-1:0] start);
        logic [SLOT_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = (int'(start) + i) % NUM_SLOTS;
            if (!found && fv[idx]) begin
                pick  = SLOT_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) free_v[s] = (state_q[s] == SLOT_FREE);
    end

    assign alloc_req_ready = |free_v;
    assign sel             = rr_pick(free_v, rr_ptr_q);
    assign alloc_fire      = alloc_req_valid && alloc_req_ready;
    assign drain_valid     = (q_count != '0);
    assign pop             = drain_valid && drain_ready;

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        first_d      = first_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = 1'b0;
        resp_slot_d  = resp_slot_q;
        err_d        = err_q;
        free_count_d = '0;

        wd_ok = write_done_valid && (int'(write_done_slot) < NUM_SLOTS) &&
                (state_q[write_done_slot] == SLOT_WRITING);
        if (write_done_valid && !wd_ok) err_d = 1'b1;

        if (alloc_fire) begin
            state_d[sel] = SLOT_WRITING;
            tag_d[sel]   = alloc_req_nodeslot;
            resp_valid_d = 1'b1;
            resp_slot_d  = sel;
            rr_ptr_d     = (sel == SLOT_W'(NUM_SLOTS - 1)) ? '0 : sel + SLOT_W'(1);
        end
        if (wd_ok) state_d[write_done_slot] = SLOT_QUEUED;
        if (pop) begin
            state_d[q_head] = SLOT_DRAINING;
            first_d[q_head] = 1'b1;
        end

        // The first DRAINING cycle covers the buffer's read latency, so slot_free_i is not trusted yet.
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (state_q[s] == SLOT_DRAINING) begin
                if (first_q[s]) first_d[s] = 1'b0;
                else if (slot_free_i[s]) state_d[s] = SLOT_FREE;
            end
        end

        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (state_d[s] == SLOT_FREE) free_count_d = free_count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= SLOT_FREE;
                tag_q[s]   <= '0;
            end
            first_q      <= '0;
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_slot_q  <= '0;
            free_count_q <= CNT_W'(NUM_SLOTS);
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            first_q      <= first_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_slot_q  <= resp_slot_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
        end
    end

    slot_ready_queue #(
        .DEPTH (NUM_SLOTS),
        .W     (SLOT_W),
        .CNT_W (CNT_W)
    ) u_ready_q (
        .clk         (core_clk),
        .rst         (reset),
        .push_i      (wd_ok),
        .push_data_i (write_done_slot),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count)
    );

    assign alloc_resp_valid = resp_valid_q;
    assign alloc_resp_slot  = resp_slot_q;
    assign drain_slot       = drain_valid ? q_head : '0;
    assign drain_nodeslot   = drain_valid ? tag_q[q_head] : '0;
    assign free_count       = free_count_q;
    assign protocol_err     = err_q;

`ifdef BUFFER_SLOT_ALLOCATOR_PERF_EN
    logic [31:0] perf_alloc_q, perf_alloc_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_alloc_d = perf_alloc_q;
        perf_stall_d = perf_stall_q;
        if (alloc_fire && (perf_alloc_q != '1)) perf_alloc_d = perf_alloc_q + 32'd1;
        if (alloc_req_valid && !alloc_req_ready && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            perf_alloc_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_alloc_q <= perf_alloc_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_alloc_count  = perf_alloc_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    // Counters are not built; allocation behaviour is unchanged.
`endif

endmodule
